conv_point_seq: RTL and testbench

- Sequential, parametrised successor to the combinational 5x5 convolution point.
- Computes one output pixel as the dot product of a KxK map window and a KxK kernel.
- Uses LANES multipliers per cycle, with valid/ready handshakes on input and output.
- Adds rounding, signed saturation and an optional per-transaction ReLU. Sits between the window buffer and the feature-map writer.

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_requant.sv | 45 ++++
 rtl/conv_point_seq.sv | 168 ++++++++++++++++
 tb/tb_conv_point_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution point datapath.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, MAC, REQ, OUT} fsm_t;

  // Accumulator wide enough that K*K full-width products can never overflow.
  function automatic int unsigned acc_width(input int unsigned bitwidth, input int unsigned k);
    return 2 * bitwidth + $clog2(k * k);
  endfunction

  function automatic int unsigned num_passes(input int unsigned k, input int unsigned lanes);
    return (k * k + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/conv_requant.sv
// Combinational requantiser: round, arithmetic shift, signed saturate, optional ReLU.
module conv_requant #(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned ACC_W    = 37,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned ROUND    = 1
) (
  input  logic signed [ACC_W-1:0]    acc_i,
  input  logic                       relu_i,
  output logic signed [BITWIDTH-1:0] value_c_o,
  output logic                       sat_c_o
);

  // One guard bit so the rounding bias cannot wrap the accumulator.
  localparam int unsigned RW    = ACC_W + 1;
  localparam int unsigned SH_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] BIAS =
    (ROUND != 0 && SHIFT > 0) ? (RW'(1) << SH_M1) : '0;
  localparam logic signed [RW-1:0] MAX_V = {{(RW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = {{(RW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
  localparam logic signed [BITWIDTH-1:0] POS_SAT = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [BITWIDTH-1:0] NEG_SAT = {1'b1, {(BITWIDTH-1){1'b0}}};

  logic signed [RW-1:0] r_c;
  logic signed [RW-1:0] r_sh_c;

  always_comb begin
    r_c       = RW'(acc_i) + BIAS;
    r_sh_c    = r_c >>> SHIFT;
    sat_c_o   = 1'b0;
    value_c_o = r_sh_c[BITWIDTH-1:0];
    if (r_sh_c > MAX_V) begin
      value_c_o = POS_SAT;
      sat_c_o   = 1'b1;
    end else if (r_sh_c < MIN_V) begin
      value_c_o = NEG_SAT;
      sat_c_o   = 1'b1;
    end
    // ReLU only zeroes the value; the clip flag reports the saturation step.
    if (relu_i && value_c_o[BITWIDTH-1]) begin
      value_c_o = '0;
    end
  end

endmodule

// File: rtl/conv_point_seq.sv
// Sequential KxK convolution point: LANES MACs per cycle, requantised, valid/ready on both sides.
module conv_point_seq
  import conv_pkg::*;
#(
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned K        = 5,
  parameter int unsigned LANES    = 5,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned ROUND    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_relu,
  input  logic [K*K*BITWIDTH-1:0]      map_block,
  input  logic [K*K*BITWIDTH-1:0]      kernel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [BITWIDTH-1:0]   value,
  output logic                         out_sat
);

  localparam int unsigned KK    = K * K;
  localparam int unsigned ACC_W = acc_width(BITWIDTH, K);
  localparam int unsigned N     = num_passes(K, LANES);
  localparam int unsigned PADN  = N * LANES;
  localparam int unsigned PW    = 2 * BITWIDTH;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W = (PADN > 1) ? $clog2(PADN) : 1;

  fsm_t                       state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [BITWIDTH-1:0] value_q, value_d;
  logic                       sat_q, sat_d;
  logic                       relu_q;
  logic                       cap_c;

  logic signed [BITWIDTH-1:0] map_q   [KK];
  logic signed [BITWIDTH-1:0] ker_q   [KK];
  logic signed [BITWIDTH-1:0] map_pad [PADN];
  logic signed [BITWIDTH-1:0] ker_pad [PADN];

  logic [IDX_W-1:0]           lane_idx_c;
  logic signed [PW-1:0]       lane_prod_c;
  logic signed [ACC_W-1:0]    lane_sum_c;
  logic signed [BITWIDTH-1:0] rq_value_c;
  logic                       rq_sat_c;

  // Zero-padded view so the final partial pass reads zeros in unused lanes.
  for (genvar e = 0; e < int'(PADN); e++) begin : g_pad
    if (e < int'(KK)) begin : g_real
      assign map_pad[e] = map_q[e];
      assign ker_pad[e] = ker_q[e];
    end else begin : g_zero
      assign map_pad[e] = '0;
      assign ker_pad[e] = '0;
    end
  end

  always_comb begin
    lane_sum_c  = '0;
    lane_idx_c  = '0;
    lane_prod_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_idx_c  = IDX_W'(cnt_q) * IDX_W'(LANES) + IDX_W'(l);
      lane_prod_c = PW'(map_pad[lane_idx_c]) * PW'(ker_pad[lane_idx_c]);
      lane_sum_c  = lane_sum_c + ACC_W'(lane_prod_c);
    end
  end

  conv_requant #(
    .BITWIDTH (BITWIDTH),
    .ACC_W    (ACC_W),
    .SHIFT    (SHIFT),
    .ROUND    (ROUND)
  ) u_requant (
    .acc_i     (acc_q),
    .relu_i    (relu_q),
    .value_c_o (rq_value_c),
    .sat_c_o   (rq_sat_c)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    value_d     = value_q;
    sat_d       = sat_q;
    cap_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cap_c      = 1'b1;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + lane_sum_c;
        if (cnt_q == CNT_W'(N - 1)) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQ: begin
        value_d     = rq_value_c;
        sat_d       = rq_sat_c;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      value_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      value_q     <= value_d;
      sat_q       <= sat_d;
    end
  end

  // Operand capture; reset on the same edge suppresses it.
  always_ff @(posedge clk) begin
    if (cap_c && !rst) begin
      relu_q <= in_relu;
      for (int e = 0; e < int'(KK); e++) begin
        map_q[e] <= map_block[e*BITWIDTH +: BITWIDTH];
        ker_q[e] <= kernel[e*BITWIDTH +: BITWIDTH];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign value     = value_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_conv_point_seq.sv
// Directed scoreboard bench for conv_point_seq across four parameter sets.
module tb_conv_point_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   iv;
  logic [3:0]   ordy;
  logic         relu;
  logic [399:0] mapb;
  logic [399:0] kerb;

  logic         ir  [4];
  logic         ov  [4];
  logic [15:0]  val [4];
  logic         sat [4];

  typedef struct {
    logic [15:0] v;
    logic        s;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_point_seq #(.BITWIDTH(16), .K(5), .LANES(5), .SHIFT(0), .ROUND(1)) u_k5 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_relu(relu),
    .map_block(mapb), .kernel(kerb), .out_valid(ov[0]), .out_ready(ordy[0]),
    .value(val[0]), .out_sat(sat[0]));

  conv_point_seq #(.BITWIDTH(16), .K(1), .LANES(1), .SHIFT(2), .ROUND(1)) u_s2r1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_relu(relu),
    .map_block(mapb[15:0]), .kernel(kerb[15:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .value(val[1]), .out_sat(sat[1]));

  conv_point_seq #(.BITWIDTH(16), .K(1), .LANES(1), .SHIFT(2), .ROUND(0)) u_s2r0 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_relu(relu),
    .map_block(mapb[15:0]), .kernel(kerb[15:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .value(val[2]), .out_sat(sat[2]));

  conv_point_seq #(.BITWIDTH(16), .K(3), .LANES(4), .SHIFT(0), .ROUND(1)) u_k3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_relu(relu),
    .map_block(mapb[143:0]), .kernel(kerb[143:0]), .out_valid(ov[3]), .out_ready(ordy[3]),
    .value(val[3]), .out_sat(sat[3]));

  function automatic logic [399:0] fill(input logic [15:0] x);
    logic [399:0] r;
    for (int i = 0; i < 25; i++) r[i*16 +: 16] = x;
    return r;
  endfunction

  function automatic logic [399:0] ramp9();
    logic [399:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*16 +: 16] = 16'(i + 1);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one pair, wait for the result, optionally stall, then drain it.
  task automatic transact(input string tag, input int s, input logic [399:0] m,
                          input logic [399:0] k, input logic r, input logic [15:0] ev,
                          input logic es, input int elat, input int hold);
    int   n;
    exp_t e;
    logic stable;
    n = 0;
    while (!ir[s] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    mapb = m; kerb = k; relu = r; iv[s] = 1'b1;
    e.v = ev; e.s = es;
    sb.push_back(e);
    @(posedge clk); #1;
    iv[s] = 1'b0;
    n = 0;
    while (!ov[s] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, n, elat);
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_value"}, val[s], e.v);
    check({tag, "_sat"}, sat[s], e.s);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!(ov[s] === 1'b1 && ir[s] === 1'b0 && val[s] === e.v && sat[s] === e.s)) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, stable, 1'b1);
    ordy[s] = 1'b1;
    @(posedge clk); #1;
    ordy[s] = 1'b0;
    check({tag, "_in_ready_after"}, ir[s], 1'b1);
    check({tag, "_out_valid_after"}, ov[s], 1'b0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; iv = '0; ordy = '0; relu = 1'b0; mapb = '0; kerb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", ir[0], 1'b1);
    check("rst_out_valid", ov[0], 1'b0);
    check("rst_value", val[0], 16'h0000);
    check("rst_sat", sat[0], 1'b0);

    transact("ones", 0, fill(16'd1), fill(16'd1), 1'b0, 16'd25, 1'b0, 6, 0);
    transact("pos_sat", 0, fill(16'h7FFF), fill(16'h7FFF), 1'b0, 16'h7FFF, 1'b1, 6, 0);
    transact("neg_sat", 0, fill(16'h8000), fill(16'h7FFF), 1'b0, 16'h8000, 1'b1, 6, 0);
    transact("neg25", 0, fill(16'hFFFF), fill(16'd1), 1'b0, 16'hFFE7, 1'b0, 6, 0);
    transact("relu", 0, fill(16'hFFFF), fill(16'd1), 1'b1, 16'h0000, 1'b0, 6, 0);
    transact("relu_sat", 0, fill(16'h8000), fill(16'h7FFF), 1'b1, 16'h0000, 1'b1, 6, 0);

    transact("rnd_pos", 1, fill(16'd2), fill(16'd3), 1'b0, 16'd2, 1'b0, 2, 0);
    transact("rnd_neg", 1, fill(16'hFFFE), fill(16'd3), 1'b0, 16'hFFFF, 1'b0, 2, 0);
    transact("trunc_pos", 2, fill(16'd2), fill(16'd3), 1'b0, 16'd1, 1'b0, 2, 0);

    transact("backpressure", 0, fill(16'd3), fill(16'd2), 1'b0, 16'd150, 1'b0, 6, 10);

    transact("k3_pad", 3, ramp9(), fill(16'd1), 1'b0, 16'd45, 1'b0, 4, 0);

    // Reset during the third MAC cycle discards the in-flight pair.
    mapb = fill(16'd7); kerb = fill(16'd7); iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midmac_rst_out_valid", ov[0], 1'b0);
    check("midmac_rst_in_ready", ir[0], 1'b1);
    transact("after_rst", 0, fill(16'd2), fill(16'd1), 1'b0, 16'd50, 1'b0, 6, 0);

    // Reset coinciding with in_valid captures nothing.
    rst = 1'b1; iv[0] = 1'b1; mapb = fill(16'd9);
    @(posedge clk); #1;
    rst = 1'b0; iv[0] = 1'b0;
    check("rst_vs_valid_in_ready", ir[0], 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) seen = 1'b1;
    end
    check("rst_vs_valid_idle", seen, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
